// File: rtl/t_param_defs.sv
// Shared state encodings and default parameters for the
// parameterized test source and its checker.
package t_param_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEF_X    = 1;
  localparam int DEF_FIVE = 5;
  localparam int DEF_TWO  = 2;

  function automatic int exp_vw(input int five, input int two);
    return (five == 5) ? two : 0;
  endfunction

endpackage

// File: rtl/t_param_satcnt.sv
// Saturating counter with synchronous clear and increment.
// Holds at all-ones instead of wrapping.
module t_param_satcnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/t_param_chk.sv
// Checker for the parameterized test source: samples par/varwidth over
// a NCYC-cycle window. Optional macro: T_PARAM_CHK_FINISH_EN.
module t_param_chk
  import t_param_defs::*;
#(
  parameter int X    = DEF_X,
  parameter int FIVE = DEF_FIVE,
  parameter int TWO  = DEF_TWO,
  parameter int NCYC = 8,
  parameter int CW   = 4
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          start,
  input  logic [4:0]    par,
  input  logic [X:0]    varwidth,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] first_bad
);

  localparam int            VW      = X + 1;
  localparam logic [4:0]    EXP_PAR = 5'(X);
  localparam logic [X:0]    EXP_VW  = VW'(exp_vw(FIVE, TWO));
  localparam logic [CW-1:0] LAST    = CW'(NCYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fb_q, fb_d;
  logic          clr, in_run, last, mism, hit;

  assign in_run = (state_q == ST_RUN);
  assign last   = (cnt_q == LAST);
  assign clr    = start &&
                  ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Case inequality so X/Z on the buses counts as a mismatch.
  assign mism   = (par !== EXP_PAR) || (varwidth !== EXP_VW);
  assign hit    = in_run && mism;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_RUN;
      ST_RUN:    if (last) state_d = ST_DONE;
      ST_DONE:   if (start) state_d = ST_SETTLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == ST_SETTLE),
      (state_q == ST_RUN):  busy = 1'b1;
      (state_q == ST_DONE): done = 1'b1;
      default: ;
    endcase
    pass = done && (err_cnt == '0);
  end

  always_comb begin
    cnt_d = cnt_q;
    fb_d  = fb_q;
    if (clr) begin
      cnt_d = '0;
      fb_d  = '0;
    end else if (in_run) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (mism && (err_cnt == '0)) fb_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt_q <= '0;
      fb_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      fb_q  <= fb_d;
    end
  end

  assign first_bad = fb_q;

  t_param_satcnt #(
    .CW(CW)
  ) u_err (
    .clk   (clk),
    .rst_n (reset_l),
    .clr_i (clr),
    .inc_i (hit),
    .cnt_o (err_cnt)
  );

`ifdef T_PARAM_CHK_FINISH_EN
  logic entered_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) entered_q <= 1'b0;
    else          entered_q <= in_run && last;
  end

  // Reported mid-cycle so the final err_cnt has settled.
  always @(negedge clk) begin
    if (entered_q && done) begin
      if (pass) begin
        $write("*-* All Finished *-*\n");
        $finish;
      end else begin
        $display("t_param_chk: err_cnt=%0d first_bad=%0d",
                 err_cnt, first_bad);
        $stop;
      end
    end
  end
`endif

endmodule

// File: tb/tb_t_param_chk.sv
// Scoreboard bench for t_param_chk across four parameter sets.
module tb_t_param_chk;

  typedef struct {
    int inst;
    int err;
    int fb;
    int pass;
  } exp_t;

  logic       clk;
  logic       reset_l;
  logic       start;
  logic [4:0] par_a, par_b, par_c, par_d;
  logic [1:0] vw_a, vw_b, vw_c;
  logic [3:0] vw_d;

  logic       busy_a, done_a, pass_a;
  logic       busy_b, done_b, pass_b;
  logic       busy_c, done_c, pass_c;
  logic       busy_d, done_d, pass_d;
  logic [3:0] err_a, fb_a, err_b, fb_b, err_d, fb_d;
  logic [2:0] err_c, fb_c;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  int NCYC_M[4] = '{8, 8, 7, 8};
  int EMAX[4]   = '{15, 15, 7, 15};

  t_param_chk u_a (
    .clk(clk), .reset_l(reset_l), .start(start),
    .par(par_a), .varwidth(vw_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_bad(fb_a)
  );

  t_param_chk #(.FIVE(0)) u_b (
    .clk(clk), .reset_l(reset_l), .start(start),
    .par(par_b), .varwidth(vw_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_bad(fb_b)
  );

  t_param_chk #(.FIVE(0), .NCYC(7), .CW(3)) u_c (
    .clk(clk), .reset_l(reset_l), .start(start),
    .par(par_c), .varwidth(vw_c),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_cnt(err_c), .first_bad(fb_c)
  );

  t_param_chk #(.X(3), .TWO(9)) u_d (
    .clk(clk), .reset_l(reset_l), .start(start),
    .par(par_d), .varwidth(vw_d),
    .busy(busy_d), .done(done_d), .pass(pass_d),
    .err_cnt(err_d), .first_bad(fb_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int mode, input int idx);
    if (idx < 0) begin
      par_a = '1; vw_a = '0; par_b = '1; vw_b = '1;
      par_c = '1; vw_c = '1; par_d = '1; vw_d = '0;
    end else begin
      par_a = 5'd1; vw_a = 2'd2;
      par_b = 5'd1; vw_b = 2'd0;
      par_c = 5'd1; vw_c = 2'd0;
      par_d = 5'd3; vw_d = 4'd9;
      case (mode)
        0: begin vw_b = 2'd2; vw_c = 2'd2; end
        1: begin
          if (idx == 3 || idx == 5) par_a = 5'd3;
          vw_c = 2'd2;
          vw_d = 4'd1;
        end
        3: par_a = 5'd0;
        default: ;
      endcase
    end
  endtask

  function automatic bit mism(input int i);
    case (i)
      0: return (par_a !== 5'd1) || (vw_a !== 2'd2);
      1: return (par_b !== 5'd1) || (vw_b !== 2'd0);
      2: return (par_c !== 5'd1) || (vw_c !== 2'd0);
      default: return (par_d !== 5'd3) || (vw_d !== 4'd9);
    endcase
  endfunction

  task automatic outs(input int i, output int err, output int fb,
                      output int ps, output int dn);
    case (i)
      0: begin err = err_a; fb = fb_a; ps = pass_a; dn = done_a; end
      1: begin err = err_b; fb = fb_b; ps = pass_b; dn = done_b; end
      2: begin err = err_c; fb = fb_c; ps = pass_c; dn = done_c; end
      default: begin
        err = err_d; fb = fb_d; ps = pass_d; dn = done_d;
      end
    endcase
  endtask

  task automatic run_window(input string tag, input int mode,
                            input bit mid, input bit from_done);
    int   lat, idx, err, fb, ps, dn;
    int   e[4], f[4];
    exp_t x;
    for (int i = 0; i < 4; i++) begin e[i] = 0; f[i] = 0; end
    drive(mode, -1);
    start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      start = mid && (lat == 4);
      if (from_done && lat == 1) begin
        check({tag, ".clr_done"}, done_a, 0);
        check({tag, ".clr_err"}, err_a, 0);
        check({tag, ".clr_busy"}, busy_a, 1);
      end
      if (!done_a) begin
        idx = lat - 2;
        drive(mode, idx);
        if (idx >= 0)
          for (int i = 0; i < 4; i++)
            if (idx < NCYC_M[i] && mism(i)) begin
              if (e[i] == 0) f[i] = idx;
              if (e[i] < EMAX[i]) e[i]++;
            end
      end
    end while (!done_a && lat < 40);
    start = 1'b0;
    check({tag, ".latency"}, lat, 10);
    for (int i = 0; i < 4; i++) begin
      x.inst = i; x.err = e[i]; x.fb = f[i];
      x.pass = (e[i] == 0) ? 1 : 0;
      sb.push_back(x);
    end
    while (sb.size() > 0) begin
      x = sb.pop_front();
      outs(x.inst, err, fb, ps, dn);
      check($sformatf("%s.%0d.done", tag, x.inst), dn, 1);
      check($sformatf("%s.%0d.err", tag, x.inst), err, x.err);
      check($sformatf("%s.%0d.first_bad", tag, x.inst), fb, x.fb);
      check($sformatf("%s.%0d.pass", tag, x.inst), ps, x.pass);
    end
    check({tag, ".busy"}, busy_a, 0);
  endtask

  initial begin
    reset_l = 1'b0;
    start   = 1'b0;
    drive(2, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", busy_a, 0);
    check("rst.done", done_a, 0);
    check("rst.pass", pass_a, 0);
    check("rst.err", err_a, 0);
    check("rst.first_bad", fb_a, 0);
    @(negedge clk);
    reset_l = 1'b1;
    @(posedge clk); #1;
    check("idle.busy", busy_a, 0);

    run_window("match_five0", 0, 1'b0, 1'b0);
    run_window("forced_sat", 1, 1'b0, 1'b0);
    run_window("restart", 2, 1'b1, 1'b1);

    drive(3, -1);
    start = 1'b1;
    for (int p = 1; p <= 6; p++) begin
      @(posedge clk); #1;
      start = 1'b0;
      drive(3, p - 2);
    end
    check("abort.err_before", err_a, 4);
    check("abort.busy_before", busy_a, 1);
    reset_l = 1'b0;
    #1;
    check("abort.busy", busy_a, 0);
    check("abort.done", done_a, 0);
    check("abort.pass", pass_a, 0);
    check("abort.err", err_a, 0);
    check("abort.first_bad", fb_a, 0);
    #2;
    reset_l = 1'b1;
    @(posedge clk); #1;
    run_window("post_rst", 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/t_param_chk.md
Name: t_param_chk

Overview:
- Downstream checker stage for the parameterized test source that drives a fixed 5-bit `par` bus and a variable-width `varwidth[X:0]` bus.
- Samples both buses over a programmed window of cycles and compares them against values computed from its own copy of the parameters.
- Counts mismatches and captures the first failing cycle.
- Reports pass/fail to the test top, which drives `start` and ends simulation.

Parameters:
- X, 1, MSB index of varwidth; must match the source instance; legal range 0..30.
- FIVE, 5, value the source is overridden with; selects the expected varwidth.
- TWO, 2, value the source drives on varwidth when FIVE==5.
- NCYC, 8, number of sampled cycles per check window; legal range 1..2**CW-1.
- CW, 4, width of the cycle and error counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_l  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a check window.
- par  in  5  sampled source output.
- varwidth  in  X+1  sampled source output.
- busy  out  1  high in SETTLE and RUN.
- done  out  1  high in DONE; sticky until the next start or reset.
- pass  out  1  valid when done=1; high iff err_cnt==0.
- err_cnt  out  CW  mismatching cycles; saturates at 2**CW-1.
- first_bad  out  CW  index (0-based) of the first mismatching RUN cycle; 0 if none.

Behaviour:
- Expected values are constants:
  - EXP_PAR = X truncated/zero-extended to 5 bits.
  - EXP_VW = (FIVE==5) ? TWO : 0, truncated/zero-extended to X+1 bits.
- Reset (reset_l=0, asynchronous): state=IDLE, busy=0, done=0, pass=0, err_cnt=0, first_bad=0, cycle counter=0. Reset mid-window aborts the window with no partial result.
- State machine:
  - IDLE: start=1 -> SETTLE, clear err_cnt, first_bad and the cycle counter.
  - SETTLE: one cycle, inputs ignored -> RUN.
  - RUN: each cycle compare par==EXP_PAR and varwidth==EXP_VW. A cycle is a mismatch if either compare fails, and counts once even if both fail. After the NCYC-th sample -> DONE.
  - DONE: done=1, pass=(err_cnt==0). start=1 -> SETTLE with counters cleared, same as from IDLE.
- start is ignored in SETTLE and RUN. There is no queued restart.
- Latency: done rises NCYC+2 cycles after the cycle in which start is sampled.
- first_bad is loaded only on the first mismatch of a window, with the current cycle index. Later mismatches leave it unchanged.
- err_cnt saturates and never wraps. pass stays 0 when err_cnt is saturated.
- The cycle counter wraps to 0 on DONE entry.
- X/Z on par or varwidth in RUN counts as a mismatch, since a case-equality compare is used.

Optional Feature:
- Macro: T_PARAM_CHK_FINISH_EN.
- Defined: on entry to DONE the block issues `$write("*-* All Finished *-*\n")` and `$finish` if pass=1. If pass=0 it issues `$display` of err_cnt and first_bad, then `$stop`.
- Undefined: no system tasks; the test top reads done/pass.

Decomposition:
- Shared package/include (t_param_defs):
  - state encodings ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_RUN=2'd2, ST_DONE=2'd3;
  - the shared default values for X/FIVE/TWO, so the source instance and checker cannot drift apart.
- One natural sub-module, t_param_satcnt: CW-bit saturating counter with clear and increment, async active-low reset. Used for err_cnt.
- Everything else stays in the parent.

Test Plan:
- Matched source (X=1, FIVE=5, TWO=2: par=5'd1, varwidth=2'd2), start pulse -> done at start+10 cycles, pass=1, err_cnt=0, first_bad=0.
- Same setup with par forced to 5'd3 during RUN cycles 3 and 5 only -> err_cnt=2, first_bad=3, pass=0.
- Checker FIVE=0 against a source driving varwidth=2 -> every cycle mismatches, err_cnt=8, first_bad=0. Then CW=3, NCYC=7 with 7 mismatches -> err_cnt saturates at 7, pass=0.
- X=3, TWO=9, FIVE=5, matched source (varwidth=4'd9, par=5'd3) -> pass=1. Source varwidth=4'd1 (TWO low bits only) -> err_cnt=8.
- reset_l pulsed low in RUN cycle 4 with prior mismatches -> all outputs 0 immediately (asynchronously). A new start gives a clean 10-cycle window.
- start re-pulsed during RUN -> ignored, done at the original time. start in DONE -> done drops the next cycle and counters clear.
